// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotates a one-hot column drive, debounces a single-row hit,
// and hands the key code out on a valid/ready port. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int REPEAT_DLY = 50,
    localparam int CW        = $clog2(ROWS * COLS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [ROWS-1:0] i_Row,
    output logic [COLS-1:0] o_Col,
    output logic [CW-1:0]   o_Key,
    output logic            o_Valid,
    input  logic            i_Ready,
    output logic            o_Overrun
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB_L   = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] row_meta_q, row_sync_q;
    logic [DW-1:0]   div_q, div_d;
    logic [COLS-1:0] col_q, col_d;
    logic [ROWS-1:0] cap_q, cap_d;
    logic [CW-1:0]   code_q, code_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CW-1:0]   key_q, key_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DLY + 1);
    localparam logic [RW-1:0] REP_L = RW'(REPEAT_DLY);
    logic [RW-1:0]   rep_q, rep_d;
`endif

    logic            sample;
    logic            row_onehot;
    logic [COLS-1:0] col_rot;
    logic [CW-1:0]   scan_code;
    logic [CW-1:0]   emit_code;
    logic            emit;
    int              r_idx, c_idx;

    assign sample     = (div_q == DIV_MAX);
    assign div_d      = sample ? '0 : div_q + DW'(1);
    assign row_onehot = ($countones(row_sync_q) == 1);
    assign col_rot    = {col_q[0], col_q[COLS-1:1]};

    // Bit MSB is index 0 on both the row and column buses.
    always_comb begin
        r_idx = 0;
        c_idx = 0;
        for (int i = 0; i < ROWS; i++) if (row_sync_q[i]) r_idx = ROWS - 1 - i;
        for (int j = 0; j < COLS; j++) if (col_q[j]) c_idx = COLS - 1 - j;
        scan_code = CW'(r_idx * COLS + c_idx);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cap_d     = cap_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = code_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_onehot) begin
                        cap_d     = row_sync_q;
                        code_d    = scan_code;
                        emit_code = scan_code;
                        if (DEBOUNCE == 1) begin
                            emit    = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_sync_q == cap_q) begin
                        if (cnt_q + 4'd1 == DEB_L) begin
                            emit    = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_rot;
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    // cnt_q counts consecutive all-zero samples toward release.
                    if (row_sync_q == '0) begin
                        if (cnt_q + 4'd1 == DEB_L) begin
                            cnt_d   = '0;
                            col_d   = col_rot;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (row_sync_q == cap_q) begin
                        if (rep_q + RW'(1) == REP_L) begin
                            emit  = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Output port: a code is transferred on any cycle with o_Valid and i_Ready both high;
    // a new code arriving while the old one is still unaccepted is dropped and flagged.
    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && i_Ready) valid_d = 1'b0;
        if (emit) begin
            if (valid_q && !i_Ready) begin
                ovr_d = 1'b1;
            end else begin
                key_d   = emit_code;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_SCAN;
            row_meta_q <= '0;
            row_sync_q <= '0;
            div_q      <= '0;
            col_q      <= {1'b1, {(COLS-1){1'b0}}};
            cap_q      <= '0;
            code_q     <= '0;
            cnt_q      <= '0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            row_meta_q <= i_Row;
            row_sync_q <= row_meta_q;
            div_q      <= div_d;
            col_q      <= col_d;
            cap_q      <= cap_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign o_Col     = col_q;
    assign o_Key     = key_q;
    assign o_Valid   = valid_q;
    assign o_Overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner at ROWS=COLS=4, SCAN_DIV=8, DEBOUNCE=3, REPEAT_DLY=5.
// Honours KEYPAD_REPEAT_EN when computing the expected repeat count.
module tb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, REPEAT_DLY = 5, CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [CW-1:0]   key;
    logic            valid;
    logic            ready;
    logic            ovr;

    int errors = 0;
    int checks = 0;
    int n_emit = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_v;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE), .REPEAT_DLY(REPEAT_DLY)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_Row(row), .o_Col(col),
        .o_Key(key), .o_Valid(valid), .i_Ready(ready), .o_Overrun(ovr)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every accepted handshake pops the oldest expected code.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            n_emit++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL key_unexpected: got %0d expected none", key);
            end else begin
                exp_v = exp_q.pop_front();
                check("key_code", key, exp_v);
            end
        end
    end

    // Returns right after the column drive moves onto column idx.
    task automatic wait_col(input int idx);
        logic [3:0] t;
        logic [3:0] prev;
        t    = 4'b1000 >> idx;
        prev = col;
        for (int k = 0; k < 600; k++) begin
            tick(1);
            if (col == t && prev != t) return;
            prev = col;
        end
        checks++;
        errors++;
        $display("FAIL wait_col_timeout: got col %b expected %b", col, t);
    endtask

    task automatic press_vec(input logic [3:0] pat, input int c, input int hold,
                             input int exp_n, input logic [3:0] code);
        int base;
        logic [3:0] t;
        t = 4'b1000 >> c;
        wait_col(c);
        base = n_emit;
        repeat (exp_n) exp_q.push_back(code);
        row = pat;
        tick(hold);
        if (exp_n > 0) check("col_frozen", col, t);
        row = '0;
        tick(40);
        check("emit_count", n_emit - base, exp_n);
        if (exp_n > 0) check("col_released", (col != t), 1);
    endtask

    typedef struct {
        logic [3:0] row;
        int         col;
        int         hold;
        int         exp_n;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int base;
        int rot;
        int exp_rep;
        logic wrapped;
        logic [3:0] prev;

        vecs[0] = '{row: 4'b0001, col: 2, hold: 48, exp_n: 1, code: 4'd14};
        vecs[1] = '{row: 4'b1000, col: 0, hold: 48, exp_n: 1, code: 4'd0};
        vecs[2] = '{row: 4'b0100, col: 1, hold: 48, exp_n: 1, code: 4'd5};
        vecs[3] = '{row: 4'b0010, col: 3, hold: 48, exp_n: 1, code: 4'd11};
        vecs[4] = '{row: 4'b1000, col: 3, hold: 48, exp_n: 1, code: 4'd3};
        vecs[5] = '{row: 4'b0001, col: 0, hold: 48, exp_n: 1, code: 4'd12};
        vecs[6] = '{row: 4'b0110, col: 0, hold: 48, exp_n: 0, code: 4'd0};

        rst   = 1'b1;
        row   = '0;
        ready = 1'b1;
        tick(2);
        check("rst_col", col, 4'b1000);
        check("rst_key", key, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", ovr, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++)
            press_vec(vecs[v].row, vecs[v].col, vecs[v].hold, vecs[v].exp_n, vecs[v].code);

        // Bounce: gone before the second sample.
        wait_col(0);
        base = n_emit;
        row = 4'b1000;
        tick(10);
        row = '0;
        tick(10);
        check("bounce_col", col, 4'b0100);
        tick(30);
        check("bounce_emits", n_emit - base, 0);

        // Ghost pattern across a full wrap.
        wait_col(0);
        base = n_emit;
        row = 4'b0110;
        prev = col;
        rot = 0;
        wrapped = 1'b0;
        for (int k = 0; k < 200 && rot < 8; k++) begin
            tick(1);
            if (col != prev) begin
                check("ghost_rotate", col, {prev[0], prev[3:1]});
                if (prev == 4'b0001 && col == 4'b1000) wrapped = 1'b1;
                rot++;
                prev = col;
            end
        end
        check("ghost_rotations", rot, 8);
        check("ghost_wrap", wrapped, 1);
        row = '0;
        tick(40);
        check("ghost_emits", n_emit - base, 0);

        // Overrun: second code dropped while the first waits.
        ready = 1'b0;
        wait_col(0);
        exp_q.push_back(4'd0);
        row = 4'b1000;
        tick(48);
        row = '0;
        tick(40);
        wait_col(1);
        row = 4'b0100;
        tick(48);
        row = '0;
        tick(40);
        check("ovr_valid", valid, 1);
        check("ovr_key", key, 0);
        check("ovr_flag", ovr, 1);
        base = n_emit;
        ready = 1'b1;
        tick(1);
        check("ovr_valid_clear", valid, 0);
        check("ovr_handshakes", n_emit - base, 1);
        check("ovr_sticky", ovr, 1);

        // Held key: initial code plus repeats when enabled.
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        wait_col(2);
        base = n_emit;
        repeat (exp_rep) exp_q.push_back(4'd14);
        row = 4'b0001;
        tick(186);
        row = '0;
        tick(40);
        check("repeat_count", n_emit - base, exp_rep);

        // Reset after the second matching sample abandons the key.
        wait_col(2);
        base = n_emit;
        row = 4'b0001;
        tick(17);
        rst = 1'b1;
        tick(1);
        check("midrst_col", col, 4'b1000);
        check("midrst_valid", valid, 0);
        check("midrst_key", key, 0);
        check("midrst_overrun", ovr, 0);
        row = '0;
        rst = 1'b0;
        tick(80);
        check("midrst_emits", n_emit - base, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of keypad columns (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clock cycles per column dwell (>=4).
REQ-004 SHALL have parameter DEBOUNCE, default 4, consecutive matching samples needed to accept a press or a release (1..15).
REQ-005 SHALL have parameter REPEAT_DLY, default 50, dwell samples between auto-repeat codes (used only with KEYPAD_REPEAT_EN).
REQ-006 SHALL have port i_clk, input, 1, the single clock; all logic rising-edge.
REQ-007 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port i_Row, input, ROWS, asynchronous active-high row sense; MSB = row 0.
REQ-009 SHALL have port o_Col, output, COLS, one-hot column drive; MSB = column 0.
REQ-010 SHALL have port o_Key, output, CW = clog2(ROWS*COLS), key code.
REQ-011 SHALL have port o_Valid, output, 1, o_Key holds an unconsumed code.
REQ-012 SHALL have port i_Ready, input, 1, consumer accepts o_Key when high with o_Valid.
REQ-013 SHALL have port o_Overrun, output, 1, sticky flag: a code was dropped.

Function
REQ-014 SHALL pass i_Row through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 SHALL hold a divider counter 0..SCAN_DIV-1; the sample point is the cycle where divider = SCAN_DIV-1.
REQ-016 SHALL run FSM states SCAN, DEBOUNCE, HELD; every state transition takes effect only at a sample point.
REQ-017 SCAN: at each sample point, if exactly one row bit is set -> capture row index r and column index c, set match count = 1, go to DEBOUNCE with o_Col frozen; otherwise rotate o_Col one position right (column COLS-1 wraps to 0).
REQ-018 SCAN: a sample with two or more row bits set (ghost/multi-key) SHALL be ignored and treated as no press.
REQ-019 DEBOUNCE: a sample equal to the captured pattern increments the match count; on reaching DEBOUNCE -> emit code, go to HELD; any other sample -> go to SCAN and rotate the column.
REQ-020 SHALL compute the code as r*COLS + c, zero-extended to CW bits.
REQ-021 HELD: o_Col stays frozen; DEBOUNCE consecutive all-zero samples -> SCAN (rotate column); any non-zero sample resets the release count.
REQ-022 Emit: in the cycle after the accepting sample, o_Key <= code and o_Valid <= 1.
REQ-023 o_Valid SHALL stay high, with o_Key stable, until a cycle where i_Ready = 1; o_Valid clears the next cycle.
REQ-024 Emit while o_Valid=1 and i_Ready=0: the new code is dropped, o_Key is unchanged, and o_Overrun <= 1 (sticky until reset).
REQ-025 Emit in the same cycle as an i_Ready handshake: the new code loads, o_Valid stays 1, and there is no overrun.
REQ-026 Press-to-o_Valid latency SHALL be at most 2 + DEBOUNCE*SCAN_DIV + 1 cycles after the column reaches the key.

Reset
REQ-027 On i_rst=1 at a clock edge: o_Col = column 0 one-hot (MSB set), o_Key = 0, o_Valid = 0, o_Overrun = 0, FSM = SCAN, and all counters and synchronizer flops = 0.
REQ-028 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abandon the key with no emission; scanning restarts from column 0.

Configuration
REQ-029 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_DLY consecutive samples still matching the captured pattern, the same code is emitted again; the repeat count then restarts, so a held key re-emits every REPEAT_DLY samples.
REQ-030 KEYPAD_REPEAT_EN undefined: exactly one emission per press; REPEAT_DLY is ignored and the repeat counter is not synthesized.

Verification (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, REPEAT_DLY=5, i_Ready=1 unless stated)
REQ-031 Stable i_Row=0001 while o_Col=0010 -> exactly one o_Valid pulse with o_Key=14; o_Col frozen at 0010 until 3 zero samples.
REQ-032 i_Row=1000 on column 0, cleared before the 2nd sample -> no o_Valid; o_Col rotates to 0100.
REQ-033 i_Row=0110 held on every column -> no o_Valid, o_Col keeps rotating with wrap 0001->1000.
REQ-034 i_Ready=0; press key 0 then key 5 -> o_Key stays 0, o_Valid stays 1, o_Overrun=1; i_Ready=1 -> o_Valid clears the next cycle.
REQ-035 i_rst pulsed after the 2nd matching sample -> o_Col=1000 and o_Valid=0 the next cycle; no code is ever emitted.
REQ-036 KEYPAD_REPEAT_EN defined, key 14 held for 20 samples after acceptance -> o_Key=14 emitted 5 times in total (the initial emission plus 4 repeats); without the macro -> 1 emission.
